// File: rtl/hash_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module   : hash_matrix_loader
// Purpose  : Loads H3 hash matrices for the cuckoo tables row by row into a
//            shadow buffer over a valid/ready stream. It then swaps the
//            complete set into the active register in one step, and only
//            while the lookup/insert datapath reports idle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   load_start_i   : pulse, begin loading a new matrix set (IDLE only)
//   load_abort_i   : pulse, drop a partial load / pending swap
//   row_data_i     : one matrix row (KEY_WIDTH bits)
//   row_valid_i    : row_data_i is valid
//   row_ready_o    : a row is accepted this cycle when valid is also high
//   busy_i         : datapath has operations in flight, so the swap waits
//   matrixes_o     : active matrix set, row (t,r) at [(t*H+r)*K +: K]
//   matrix_valid_o : at least one set has been committed since reset
//   swap_done_o    : one-cycle pulse after a commit
//   loading_o      : a load or a pending swap is in progress
//   epoch_o        : commit counter, wraps 255 -> 0
// ============================================================================
module hash_matrix_loader #(
    parameter int NUMBER_OF_TABLES = 4,
    parameter int HASH_ADR_WIDTH   = 5,
    parameter int KEY_WIDTH        = 2
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                load_start_i,
    input  logic                                                load_abort_i,
    input  logic [KEY_WIDTH-1:0]                                row_data_i,
    input  logic                                                row_valid_i,
    output logic                                                row_ready_o,
    input  logic                                                busy_i,
    output logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH*KEY_WIDTH-1:0] matrixes_o,
    output logic                                                matrix_valid_o,
    output logic                                                swap_done_o,
    output logic                                                loading_o,
    output logic [7:0]                                          epoch_o
);

    localparam int c_ROWS  = NUMBER_OF_TABLES * HASH_ADR_WIDTH;
    localparam int c_CNT_W = (c_ROWS > 1) ? $clog2(c_ROWS) : 1;
    localparam int c_MAT_W = c_ROWS * KEY_WIDTH;
    localparam logic [c_CNT_W-1:0] c_LAST_ROW = c_CNT_W'(c_ROWS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [KEY_WIDTH-1:0] r_shadow [c_ROWS];
    logic [c_MAT_W-1:0]   w_shadow_flat;
    logic [c_MAT_W-1:0]   r_matrixes;
    logic                 r_valid;
    logic                 r_swap_done;
    logic [7:0]           r_epoch;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_commit;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state. Abort wins over both row acceptance and the swap.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (load_start_i) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (load_abort_i) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (row_valid_i && (r_cnt == c_LAST_ROW)) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (load_abort_i || !busy_i) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs and strobes, all decoded from the state register so that
    // row_ready_o has no combinational path from row_valid_i.
    // ------------------------------------------------------------------------
    always_comb begin
        row_ready_o = 1'b0;
        loading_o   = 1'b0;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_start = load_start_i;
            end
            c_ST_LOAD: begin
                row_ready_o = 1'b1;
                loading_o   = 1'b1;
                w_accept    = row_valid_i && !load_abort_i;
            end
            c_ST_WAIT: begin
                loading_o = 1'b1;
                w_commit  = !busy_i && !load_abort_i;
            end
            default: ;
        endcase
    end

    // Flatten the shadow rows with the same packing used by the active set.
    for (genvar g = 0; g < c_ROWS; g++) begin : g_pack
        assign w_shadow_flat[g*KEY_WIDTH +: KEY_WIDTH] = r_shadow[g];
    end

    // ------------------------------------------------------------------------
    // Datapath. The shadow is not cleared on start because every entry is
    // rewritten before a commit can happen.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_matrixes  <= '0;
            r_valid     <= 1'b0;
            r_swap_done <= 1'b0;
            r_epoch     <= 8'd0;
            for (int i = 0; i < c_ROWS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_swap_done <= w_commit;
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_shadow[r_cnt] <= row_data_i;
            end
            if (w_commit) begin
                r_matrixes <= w_shadow_flat;
                r_valid    <= 1'b1;
                r_epoch    <= r_epoch + 8'd1;
            end
        end
    end

    assign matrixes_o     = r_matrixes;
    assign matrix_valid_o = r_valid;
    assign swap_done_o    = r_swap_done;
    assign epoch_o        = r_epoch;

endmodule
`default_nettype wire
